// File: rtl/gpio_blink_monitor.sv
// Multi-channel GPIO blink checker; optional glitch filter under GPIO_BLINK_GLITCH_FILTER_EN.
// Count latency 2 edges after s1 capture (+FILT_LEN when filtered); no backpressure, all outputs registered.
module gpio_blink_monitor #(
  parameter int NCH      = 16,
  parameter int CNT_W    = 8,
  parameter int TMO_W    = 24,
  parameter int FILT_LEN = 4
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 enable,
  input  logic [NCH-1:0]       gpio_in,
  input  logic [NCH-1:0]       chan_mask,
  input  logic [CNT_W-1:0]     expected_blinks,
  input  logic [TMO_W-1:0]     timeout_cycles,
  output logic [NCH*CNT_W-1:0] blink_count,
  output logic [1:0]           state,
  output logic                 done,
  output logic                 pass,
  output logic                 fail
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           st;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   lvl;
  logic [NCH-1:0]   prev_lvl;
  logic [NCH-1:0]   fall;
  logic [CNT_W-1:0] cnt [NCH];
  logic [TMO_W-1:0] tmo_cnt;
  logic [NCH-1:0]   mask_lat;
  logic [CNT_W-1:0] exp_lat;
  logic [TMO_W-1:0] tmo_lat;
  logic             all_met;
  logic             tmo_hit;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync1    <= '0;
      sync2    <= '0;
      prev_lvl <= '0;
    end else begin
      sync1    <= gpio_in;
      sync2    <= sync1;
      prev_lvl <= lvl;
    end
  end

`ifdef GPIO_BLINK_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN);

  logic [NCH-1:0] filt_lvl;
  logic [FW-1:0]  filt_cnt [NCH];

  // The filtered level flips once s2 has disagreed with it for FILT_LEN straight cycles.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      filt_lvl <= '0;
      for (int i = 0; i < NCH; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == filt_lvl[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FW'(FILT_LEN - 1)) begin
          filt_lvl[i] <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FW'(1);
        end
      end
    end
  end

  assign lvl = filt_lvl;
`else
  logic unused_filt_len;
  assign unused_filt_len = (FILT_LEN != 0);
  assign lvl = sync2;
`endif

  assign fall = prev_lvl & ~lvl;

  always_comb begin
    all_met = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (mask_lat[i] && (cnt[i] < exp_lat)) all_met = 1'b0;
    end
  end

  assign tmo_hit = (tmo_lat != '0) && (tmo_cnt == tmo_lat - TMO_W'(1));

  always_ff @(posedge clock) begin
    if (!resetb) begin
      st       <= ST_IDLE;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      tmo_cnt  <= '0;
      mask_lat <= '0;
      exp_lat  <= '0;
      tmo_lat  <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (enable) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            tmo_cnt  <= '0;
            mask_lat <= chan_mask;
            exp_lat  <= expected_blinks;
            tmo_lat  <= timeout_cycles;
            st       <= ST_RUN;
          end
        end
        ST_RUN: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          for (int i = 0; i < NCH; i++) begin
            if (fall[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
          end
          // Pass is checked before timeout so a tie resolves to PASS.
          if (!enable) begin
            st <= ST_IDLE;
          end else if (all_met) begin
            st   <= ST_PASS;
            done <= 1'b1;
            pass <= 1'b1;
          end else if (tmo_hit) begin
            st   <= ST_FAIL;
            done <= 1'b1;
            fail <= 1'b1;
          end
        end
        default: begin
          if (!enable) begin
            st   <= ST_IDLE;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign blink_count[g*CNT_W +: CNT_W] = cnt[g];
  end

  assign state = st;

endmodule

// File: tb/tb_gpio_blink_monitor.sv
// Self-checking bench for gpio_blink_monitor: vector table, corner sequences, randomized model check.
module tb_gpio_blink_monitor;
  localparam int NCH   = 16;
  localparam int CNT_W = 8;
  localparam int TMO_W = 24;
`ifdef GPIO_BLINK_GLITCH_FILTER_EN
  localparam int F = 4;
`else
  localparam int F = 0;
`endif
  localparam int MINSEG = (F == 0) ? 1 : F;
  localparam int INF    = 1 << 30;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 resetb;
  logic                 enable;
  logic [NCH-1:0]       gpio_in;
  logic [NCH-1:0]       chan_mask;
  logic [CNT_W-1:0]     expected_blinks;
  logic [TMO_W-1:0]     timeout_cycles;
  logic [NCH*CNT_W-1:0] blink_count;
  logic [1:0]           state;
  logic                 done, pass, fail;

  logic        s_enable;
  logic [3:0]  s_gpio, s_mask, s_exp;
  logic [15:0] s_tmo, s_count;
  logic [1:0]  s_state;
  logic        s_done, s_pass, s_fail;

  gpio_blink_monitor dut (
    .clock(clock), .resetb(resetb), .enable(enable), .gpio_in(gpio_in),
    .chan_mask(chan_mask), .expected_blinks(expected_blinks), .timeout_cycles(timeout_cycles),
    .blink_count(blink_count), .state(state), .done(done), .pass(pass), .fail(fail)
  );

  gpio_blink_monitor #(.NCH(4), .CNT_W(4), .TMO_W(16), .FILT_LEN(4)) dut_s (
    .clock(clock), .resetb(resetb), .enable(s_enable), .gpio_in(s_gpio),
    .chan_mask(s_mask), .expected_blinks(s_exp), .timeout_cycles(s_tmo),
    .blink_count(s_count), .state(s_state), .done(s_done), .pass(s_pass), .fail(s_fail)
  );

  typedef struct {
    int          w;
    logic [15:0] mask;
    int          expb;
    int          tmo;
    int          p0;
    int          p1;
    logic [1:0]  st;
    int          c0;
    int          c1;
    int          rel;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;
  int   done_edge = -1;
  int   s_done_edge = -1;
  int   falls[NCH][$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
    if (done === 1'b1 && done_edge < 0) done_edge = edge_n;
    if (s_done === 1'b1 && s_done_edge < 0) s_done_edge = edge_n;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int entry, np, act_rel;
    logic [NCH*CNT_W-1:0] exp_bus;
    enable = 1'b0;
    gpio_in = '0;
    repeat (3) tick();
    chan_mask = v.mask;
    expected_blinks = CNT_W'(v.expb);
    timeout_cycles = TMO_W'(v.tmo);
    enable = 1'b1;
    entry = edge_n + 1;
    done_edge = -1;
    np = (v.p0 > v.p1) ? v.p0 : v.p1;
    for (int j = 0; j < np; j++) begin
      gpio_in = '0;
      gpio_in[0] = (j < v.p0);
      gpio_in[1] = (j < v.p1);
      repeat (v.w) tick();
      gpio_in = '0;
      repeat (v.w) tick();
    end
    if (v.rel < 0) repeat (20) tick();
    else for (int k = 0; k < 1100 && done_edge < 0; k++) tick();
    repeat (2) tick();
    exp_bus = '0;
    exp_bus[7:0] = 8'(v.c0);
    exp_bus[15:8] = 8'(v.c1);
    act_rel = (done_edge < 0) ? -1 : done_edge - entry;
    check($sformatf("vec%0d state", idx), state, v.st);
    check($sformatf("vec%0d counts", idx), blink_count, exp_bus);
    check($sformatf("vec%0d done_time", idx), act_rel, v.rel);
    check($sformatf("vec%0d flags", idx), {done, pass, fail},
          {v.st >= 2'd2, v.st == 2'd2, v.st == 2'd3});
  endtask

  task automatic rand_trial(input int tr);
    int entry, fin, pe, fe, endv, maxseg, n, found, c, e, t, exp_done;
    int seg[NCH];
    logic [NCH-1:0] lvl, m;
    logic [NCH*CNT_W-1:0] exp_bus;
    logic [1:0] exp_st;
    enable = 1'b0;
    repeat (3) tick();
    m = NCH'($urandom & $urandom);
    e = $urandom_range(0, 8);
    t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(10, 300);
    maxseg = $urandom_range(MINSEG + 2, 40);
    chan_mask = m;
    expected_blinks = CNT_W'(e);
    timeout_cycles = TMO_W'(t);
    enable = 1'b1;
    entry = edge_n + 1;
    done_edge = -1;
    tick();
    lvl = gpio_in;
    for (int ch = 0; ch < NCH; ch++) begin
      falls[ch].delete();
      seg[ch] = $urandom_range(1, maxseg);
    end
    for (int s = 0; s < 250; s++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (seg[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          if (!lvl[ch]) falls[ch].push_back(edge_n + 3 + F);
          seg[ch] = $urandom_range(MINSEG, maxseg);
        end
        seg[ch]--;
      end
      gpio_in = lvl;
      chan_mask = NCH'($urandom);
      expected_blinks = CNT_W'($urandom);
      timeout_cycles = TMO_W'($urandom);
      tick();
    end
    repeat (8 + F) tick();
    fin = edge_n;
    // Reference: pass edge is one after the e-th counted fall on the slowest masked channel.
    pe = entry + 1;
    if (m != '0 && e != 0) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (m[ch]) begin
          n = 0;
          found = INF;
          foreach (falls[ch][i]) begin
            if (falls[ch][i] > entry) begin
              n++;
              if (n == e) found = falls[ch][i] + 1;
            end
          end
          if (found > pe) pe = found;
        end
      end
    end
    fe = (t != 0) ? entry + t : INF;
    endv = (pe <= fe) ? pe : fe;
    if (endv > fin) begin
      exp_st = 2'd1;
      exp_done = -1;
      endv = fin;
    end else begin
      exp_st = (pe <= fe) ? 2'd2 : 2'd3;
      exp_done = endv;
    end
    exp_bus = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      c = 0;
      foreach (falls[ch][i]) if (falls[ch][i] > entry && falls[ch][i] <= endv) c++;
      if (c > 255) c = 255;
      exp_bus[ch*CNT_W +: CNT_W] = CNT_W'(c);
    end
    check($sformatf("rand%0d state", tr), state, exp_st);
    check($sformatf("rand%0d counts", tr), blink_count, exp_bus);
    check($sformatf("rand%0d done_edge", tr), done_edge, exp_done);
  endtask

  initial begin
    int entry;
    vecs[0] = '{3,  16'h0000, 5,  0,      3,  0, 2'd2, 0,  0, 1};
    vecs[1] = '{3,  16'h0001, 0,  0,      2,  0, 2'd2, 0,  0, 1};
    vecs[2] = '{3,  16'h0001, 3,  0,      3,  0, 2'd2, 3,  0, 18 + F};
    vecs[3] = '{3,  16'h0003, 3,  0,      3,  2, 2'd1, 3,  2, -1};
    vecs[4] = '{3,  16'h0002, 2,  0,      5,  2, 2'd2, 2,  2, 12 + F};
    vecs[5] = '{3,  16'h0001, 5,  29 + F, 5,  0, 2'd3, 5,  0, 29 + F};
    vecs[6] = '{3,  16'h0001, 5,  30 + F, 5,  0, 2'd2, 5,  0, 30 + F};
    vecs[7] = '{50, 16'h0001, 10, 0,      10, 0, 2'd2, 10, 0, 953 + F};
    vecs[8] = '{3,  16'h0003, 5,  1000,   5,  4, 2'd3, 5,  4, 1000};
    vecs[9] = '{3,  16'h0001, 1,  1,      1,  0, 2'd3, 0,  0, 1};

    resetb = 1'b0;
    enable = 1'b0;
    gpio_in = '0;
    chan_mask = '0;
    expected_blinks = '0;
    timeout_cycles = '0;
    s_enable = 1'b0;
    s_gpio = '0;
    s_mask = '0;
    s_exp = '0;
    s_tmo = '0;
    repeat (3) tick();
    check("reset state", state, 2'd0);
    check("reset counts", blink_count, '0);
    check("reset flags", {done, pass, fail}, 3'b000);
    check("reset small counts", s_count, 16'h0000);
    resetb = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset in the middle of a run, then re-enable.
    enable = 1'b0;
    gpio_in = '0;
    repeat (3) tick();
    chan_mask = 16'h0001;
    expected_blinks = 8'd10;
    timeout_cycles = '0;
    enable = 1'b1;
    for (int j = 0; j < 3; j++) begin
      gpio_in[0] = 1'b1;
      repeat (3) tick();
      gpio_in[0] = 1'b0;
      repeat (3) tick();
    end
    repeat (10) tick();
    check("midrun count0", blink_count[7:0], 8'd3);
    check("midrun state", state, 2'd1);
    resetb = 1'b0;
    tick();
    check("after reset state", state, 2'd0);
    check("after reset counts", blink_count, '0);
    check("after reset done", done, 1'b0);
    resetb = 1'b1;
    tick();
    check("reenable state", state, 2'd1);
    check("reenable counts", blink_count, '0);
    gpio_in[0] = 1'b1;
    repeat (3) tick();
    gpio_in[0] = 1'b0;
    repeat (11) tick();
    check("reenable count0", blink_count[7:0], 8'd1);
    enable = 1'b0;
    repeat (2) tick();
    check("disable state", state, 2'd0);
    check("disable held count0", blink_count[7:0], 8'd1);

    // Short low glitches between long highs.
    enable = 1'b1;
    tick();
    gpio_in[0] = 1'b1;
    repeat (6) tick();
    for (int j = 0; j < 3; j++) begin
      gpio_in[0] = 1'b0;
      repeat (2) tick();
      gpio_in[0] = 1'b1;
      repeat (6) tick();
    end
    gpio_in[0] = 1'b0;
    repeat (12) tick();
    check("glitch count0", blink_count[7:0], (F == 0) ? 8'd4 : 8'd1);
    check("glitch state", state, 2'd1);
    enable = 1'b0;

    // Narrow-counter instance: saturation, then pass on the 15th pulse.
    s_mask = 4'h1;
    s_exp = 4'd15;
    s_tmo = '0;
    s_enable = 1'b1;
    tick();
    for (int j = 0; j < 20; j++) begin
      s_gpio = {1'b1, 1'b1, 1'b0, (j < 14)};
      repeat (5) tick();
      s_gpio = '0;
      repeat (5) tick();
    end
    repeat (10) tick();
    check("sat state", s_state, 2'd1);
    check("sat counts", s_count, 16'hFF0E);
    s_enable = 1'b0;
    repeat (3) tick();
    s_mask = 4'h4;
    s_enable = 1'b1;
    s_done_edge = -1;
    entry = edge_n + 1;
    for (int j = 0; j < 20; j++) begin
      s_gpio = 4'b0100;
      repeat (5) tick();
      s_gpio = '0;
      repeat (5) tick();
    end
    repeat (10) tick();
    check("sat pass state", s_state, 2'd2);
    check("sat pass counts", s_count, 16'h0F00);
    check("sat pass time", s_done_edge - entry, 148 + F);
    check("sat pass flags", {s_done, s_pass, s_fail}, 3'b110);
    s_enable = 1'b0;

    for (int tr = 0; tr < 40; tr++) rand_trial(tr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpio_blink_monitor.md
# gpio_blink_monitor

Parametrised, synthesizable multi-channel GPIO activity checker for the management SoC verification and bring-up path. It counts complete high-to-low pulses ("blinks") on up to NCH GPIO lines, compares them against a programmed target within a cycle budget, and reports sticky pass/fail. It generalises the single-line, fixed-count blink check into masked multi-channel counting with a configurable timeout and optional glitch rejection.

## Interface
- NCH, 16, number of monitored GPIO channels (1..38)
- CNT_W, 8, per-channel blink counter width
- TMO_W, 24, timeout counter width
- FILT_LEN, 4, glitch filter stability length in cycles (2..15); used only with GPIO_BLINK_GLITCH_FILTER_EN
- clock  in  1  system clock; all logic on rising edge
- resetb  in  1  reset; one clock; reset is synchronous and active-low
- enable  in  1  level; rising run request; low returns to IDLE
- gpio_in  in  NCH  asynchronous GPIO levels (pad side)
- chan_mask  in  NCH  1 = channel participates in pass check
- expected_blinks  in  CNT_W  required blinks per masked channel
- timeout_cycles  in  TMO_W  cycle budget in RUN; 0 = no timeout
- blink_count  out  NCH*CNT_W  per-channel counts, channel i at [i*CNT_W +: CNT_W]
- state  out  2  0 IDLE, 1 RUN, 2 PASS, 3 FAIL
- done  out  1  state is PASS or FAIL
- pass  out  1  state is PASS
- fail  out  1  state is FAIL

## Operation
- Each gpio_in bit passes through a 2-flop synchroniser (s2), then a previous-sample register p.
- Blink on channel i: p=1 and s2=0 (falling edge) while state is RUN. A line already high at run start counts on its first fall.
- Counters saturate at 2^CNT_W-1; never wrap.
- IDLE: counters hold. When enable=1: clear all counters and the timeout counter, latch chan_mask/expected_blinks/timeout_cycles into shadow registers, go to RUN. Inputs changing during RUN have no effect.
- RUN: the timeout counter increments every cycle. Pass condition: every masked channel has registered count >= latched expected. Evaluated on registered counts every RUN cycle.
  - Pass condition true -> PASS.
  - Otherwise, if latched timeout is nonzero and the timeout counter equals timeout-1 -> FAIL.
  - If both hold in the same cycle, PASS wins.
  - enable=0 -> IDLE; counts are held for readout.
- PASS/FAIL: sticky; counters frozen; enable=0 -> IDLE.
- Degenerate cases: a latched mask of 0 or an expected count of 0 reaches PASS on the first RUN cycle.
- Reset (including mid-RUN): state IDLE, all counters 0, synchroniser/p/filter registers 0, shadow registers 0.

## Timing
- Outputs are registered. Reset values: blink_count=0, state=0, done=0, pass=0, fail=0.
- Input latency: the falling level is captured into s1 at edge N, into s2 at N+1, and blink_count increments at edge N+2. The pass transition follows one edge later (N+3).
- IDLE->RUN: state=1 on the edge that samples enable=1; counting is active from the next edge.
- Timeout: FAIL appears exactly timeout_cycles edges after entering RUN.
- A minimum blink requires 1 cycle high and 1 cycle low at s2. Shorter pulses may be lost without the filter.

## Configuration
- GPIO_BLINK_GLITCH_FILTER_EN defined:
  - A per-channel filtered level replaces s2. It changes only after s2 has held the new value for FILT_LEN consecutive cycles.
  - Adds FILT_LEN cycles of latency.
  - Pulses shorter than FILT_LEN cycles are ignored.
- Undefined: s2 feeds edge detection directly; no filter counters are built; FILT_LEN is ignored.

## Test plan
- NCH=16, mask=0x0001, expected=10, timeout=0; 10 pulses of 50 high/50 low on ch0 -> count0=10, pass=1, state=2; blink_count for all other channels is 0.
- mask=0x0003, expected=5, timeout=1000; ch0 5 pulses, ch1 4 pulses -> fail=1 exactly 1000 cycles after RUN entry; count1=4.
- Saturation: CNT_W=4, expected=15, 20 pulses on ch2 with mask=0x0004 -> pass at the 15th pulse; counter frozen at 15.
- Edge ordering: the 5th pulse on the last masked channel completes on the same cycle the timeout expires -> pass=1, fail=0.
- Filter on, FILT_LEN=4: 2-cycle low glitches -> count unchanged. 6-cycle low pulse -> count+1, with 4 extra cycles of latency versus filter off.
- Reset mid-RUN with count0=3 -> next cycle state=0, all counts 0, done=0. Re-enable -> RUN with cleared counters.
